// File: rtl/systolic_array_mm.sv
// Output-stationary NxN systolic matrix multiplier (C = A*B), operands skewed internally.
// Build option: define SYSTOLIC_SIGNED_EN for two's-complement operands and results.
module systolic_array_mm #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int CW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*DW-1:0]   A,
    input  logic [N*DW-1:0]   B,
    output logic [N*N*CW-1:0] C,
    output logic              valid
);

    localparam int CNT_MAX = 3 * (N - 1);
    localparam int CTW     = $clog2(CNT_MAX + 2);

    logic [CTW-1:0] cnt;
    logic           in_phase;

    // a_h[i][j] / b_v[i][j] are the operands presented to PE(i,j) this cycle
    logic [DW-1:0] a_h [N][N];
    logic [DW-1:0] b_v [N][N];

    assign in_phase = (cnt < CTW'(N));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            valid <= 1'b0;
        end else begin
            if (cnt != CTW'(CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
            if (cnt == CTW'(CNT_MAX)) begin
                valid <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row_skew
        logic [DW-1:0] a_g;
        assign a_g = in_phase ? A[i*DW +: DW] : '0;

        if (i == 0) begin : g_nodly
            assign a_h[i][0] = a_g;
        end else begin : g_dly
            logic [DW-1:0] sr [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < i; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= a_g;
                    for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
                end
            end
            assign a_h[i][0] = sr[i-1];
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_col_skew
        logic [DW-1:0] b_g;
        assign b_g = in_phase ? B[j*DW +: DW] : '0;

        if (j == 0) begin : g_nodly
            assign b_v[0][j] = b_g;
        end else begin : g_dly
            logic [DW-1:0] sr [j];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < j; k++) sr[k] <= '0;
                end else begin
                    sr[0] <= b_g;
                    for (int k = 1; k < j; k++) sr[k] <= sr[k-1];
                end
            end
            assign b_v[0][j] = sr[j-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_pe_row
        for (genvar j = 0; j < N; j++) begin : g_pe_col
            logic [CW-1:0] acc;
            logic [CW-1:0] addend;
`ifdef SYSTOLIC_SIGNED_EN
            logic signed [2*DW-1:0] prod;
            assign prod = $signed({{DW{a_h[i][j][DW-1]}}, a_h[i][j]})
                        * $signed({{DW{b_v[i][j][DW-1]}}, b_v[i][j]});
`else
            logic [2*DW-1:0] prod;
            assign prod = {{DW{1'b0}}, a_h[i][j]} * {{DW{1'b0}}, b_v[i][j]};
`endif
            // Size cast sign-extends in the signed build, zero-extends otherwise
            assign addend = CW'(prod);

            // Freezing on valid keeps results stable even if the drain ever saw stray data
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc <= '0;
                end else if (!valid) begin
                    acc <= acc + addend;
                end
            end
            assign C[(i*N+j)*CW +: CW] = acc;

            if (j < N - 1) begin : g_pass_a
                logic [DW-1:0] a_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) a_q <= '0;
                    else      a_q <= a_h[i][j];
                end
                assign a_h[i][j+1] = a_q;
            end

            if (i < N - 1) begin : g_pass_b
                logic [DW-1:0] b_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) b_q <= '0;
                    else      b_q <= b_v[i][j];
                end
                assign b_v[i+1][j] = b_q;
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_mm.sv
// Self-checking bench for systolic_array_mm against a matrix-product reference model.
module tb_systolic_array_mm;

    localparam int N    = 3;
    localparam int DW   = 8;
    localparam int CW   = 16;
    localparam int LAST = 3 * (N - 1);

    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   A;
    logic [N*DW-1:0]   B;
    logic [N*N*CW-1:0] C;
    logic              valid;

    logic [DW-1:0] ma [N][N];
    logic [DW-1:0] mb [N][N];

    int checks = 0;
    int errors = 0;

    systolic_array_mm #(.N(N), .DW(DW), .CW(CW)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .C     (C),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int elem(input logic [DW-1:0] v);
`ifdef SYSTOLIC_SIGNED_EN
        return int'($signed(v));
`else
        return int'(v);
`endif
    endfunction

    // Expected C(i,j) after edge e: the k-th product lands on edge k+i+j
    function automatic logic [CW-1:0] model_c(input int i, input int j, input int e);
        int s;
        s = 0;
        for (int k = 0; k < N; k++)
            if (k + i + j <= e) s += elem(ma[i][k]) * elem(mb[k][j]);
        return s[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] c_at(input int i, input int j);
        return C[(i*N+j)*CW +: CW];
    endfunction

    task automatic load_spec(input int v);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = DW'(i * N + k + 1);
                mb[i][k] = (v == 0) ? DW'(i * N + k + 1) : DW'(N * N - (i * N + k));
            end
    endtask

    task automatic load_random();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) begin
                ma[i][k] = DW'($urandom);
                mb[i][k] = DW'($urandom);
            end
    endtask

    // Called at a falling edge; leaves the bench at the falling edge after edge e
    task automatic drive_edge(input int e, input bit junk);
        for (int i = 0; i < N; i++) begin
            A[i*DW +: DW] = (e < N) ? ma[i][e] : (junk ? DW'($urandom) : '0);
            B[i*DW +: DW] = (e < N) ? mb[e][i] : (junk ? DW'($urandom) : '0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_run();
        A   = '0;
        B   = '0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        A   = '1;
        B   = '1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (C !== '0) begin
            errors++;
            $display("FAIL reset_c: got %h expected 0", C);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", valid);
        end
    endtask

    task automatic test_products();
        logic exp_v;
        for (int v = 0; v < 6; v++) begin
            if (v < 2) load_spec(v);
            else       load_random();
            start_run();
            for (int e = 0; e <= LAST + 2; e++) begin
                drive_edge(e, 1'b0);
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) begin
                        checks++;
                        if (c_at(i, j) !== model_c(i, j, e)) begin
                            errors++;
                            $display("FAIL product v%0d C(%0d,%0d) edge %0d: got %0d expected %0d",
                                     v, i, j, e, c_at(i, j), model_c(i, j, e));
                        end
                    end
                exp_v = (e >= LAST);
                checks++;
                if (valid !== exp_v) begin
                    errors++;
                    $display("FAIL product_valid v%0d edge %0d: got %b expected %b", v, e, valid, exp_v);
                end
            end
        end
    endtask

    task automatic test_junk_hold();
        logic exp_v;
        load_spec(1);
        start_run();
        for (int e = 0; e < N + 20; e++) begin
            drive_edge(e, 1'b1);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (c_at(i, j) !== model_c(i, j, e)) begin
                        errors++;
                        $display("FAIL junk_hold C(%0d,%0d) edge %0d: got %0d expected %0d",
                                 i, j, e, c_at(i, j), model_c(i, j, e));
                    end
                end
            exp_v = (e >= LAST);
            checks++;
            if (valid !== exp_v) begin
                errors++;
                $display("FAIL junk_valid edge %0d: got %b expected %b", e, valid, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        load_spec(0);
        start_run();
        for (int e = 0; e <= 3; e++) drive_edge(e, 1'b0);
        checks++;
        if (c_at(0, 0) !== model_c(0, 0, 3)) begin
            errors++;
            $display("FAIL async_pre C(0,0): got %0d expected %0d", c_at(0, 0), model_c(0, 0, 3));
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (C !== '0) begin
            errors++;
            $display("FAIL async_mid_c: got %h expected 0", C);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL async_mid_valid: got %b expected 0", valid);
        end
        @(negedge clk);
        rst = 1'b1;
        load_random();
        for (int e = 0; e <= LAST + 1; e++) drive_edge(e, 1'b1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                checks++;
                if (c_at(i, j) !== model_c(i, j, LAST)) begin
                    errors++;
                    $display("FAIL async_fresh C(%0d,%0d): got %0d expected %0d",
                             i, j, c_at(i, j), model_c(i, j, LAST));
                end
            end
        checks++;
        if (valid !== 1'b1) begin
            errors++;
            $display("FAIL async_fresh_valid: got %b expected 1", valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (C !== '0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL async_after_valid: got C=%h valid=%b expected 0/0", C, valid);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_extremes();
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < N; i++)
                for (int k = 0; k < N; k++) begin
`ifdef SYSTOLIC_SIGNED_EN
                    ma[i][k] = (t == 0 || i == k) ? 8'hFF : 8'h00;
                    mb[i][k] = (i == k) ? 8'h01 : 8'h00;
`else
                    ma[i][k] = (t == 0 || i == k) ? 8'hFF : 8'h00;
                    mb[i][k] = (t == 0 || i == k) ? 8'hFF : 8'h00;
`endif
                end
            start_run();
            for (int e = 0; e <= LAST + 1; e++) drive_edge(e, 1'b0);
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    checks++;
                    if (c_at(i, j) !== model_c(i, j, LAST)) begin
                        errors++;
                        $display("FAIL extreme t%0d C(%0d,%0d): got %0d expected %0d",
                                 t, i, j, c_at(i, j), model_c(i, j, LAST));
                    end
                end
        end
    endtask

    initial begin
        rst = 1'b0;
        A   = '0;
        B   = '0;
        test_reset();
        test_products();
        test_junk_hold();
        test_async_reset();
        test_extremes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
